// File: rtl/dmem_resp.sv
// Data-memory responder: byte-addressable word SRAM behind a single-outstanding
// load/store handshake. Optional misalignment trap is enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_resp #(
    parameter  int DEPTH_WORDS = 1024,
    parameter  int LATENCY     = 1,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [2:0]  i_dmem_opsel,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err
);

    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Access size: 0 = byte, 1 = halfword, 2 = word (illegal encodings fall to word)
    function automatic logic [1:0] acc_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 2'd0;
            3'b001, 3'b101: return 2'd1;
            default:        return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] align_ofs(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return a;
            2'd1:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] sz);
        return ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a != 2'b00));
    endfunction
`endif

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  ofs,
                                                input logic [2:0]  op);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        b  = word[{ofs, 3'b000} +: 8];
        h  = ofs[1] ? word[31:16] : word[15:0];
        sb = b;
        sh = h;
        case (acc_size(op))
            2'd0:    return op[2] ? 32'(b) : 32'(sb);
            2'd1:    return op[2] ? 32'(h) : 32'(sh);
            default: return word;
        endcase
    endfunction

    logic [31:0]   mem [DEPTH_WORDS];

    state_t        state;
    logic [CNT_W-1:0] cnt;

    logic [AW+1:0] req_addr_p0;
    logic [31:0]   req_wdata_p0;
    logic [2:0]    req_opsel_p0;
    logic          req_store_p0;

    logic [31:0]   rd_word_p1;
    logic [1:0]    ofs_p1;
    logic [2:0]    opsel_p1;
    logic          store_p1;
    logic          misal_p1;

    logic          accept;
    logic          go_resp;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_opsel;
    logic          cur_store;
    logic [1:0]    cur_size;
    logic [1:0]    cur_ofs;
    logic          cur_misal;
    logic [AW-1:0] cur_idx;
    logic [3:0]    cur_be;
    logic [31:0]   cur_lane;

    logic          unused_addr;
    assign unused_addr = ^i_dmem_addr[31:AW+2];

    assign o_dmem_ready = (state == S_IDLE) && !i_rst;
    assign accept       = o_dmem_ready && (i_dmem_ren || i_dmem_wen);

    // With LATENCY 1 the access happens on the accept edge, so take fields straight from the inputs
    always_comb begin
        cur_addr  = (state == S_IDLE) ? i_dmem_addr[AW+1:0] : req_addr_p0;
        cur_wdata = (state == S_IDLE) ? i_dmem_wdata        : req_wdata_p0;
        cur_opsel = (state == S_IDLE) ? i_dmem_opsel        : req_opsel_p0;
        cur_store = (state == S_IDLE) ? i_dmem_wen          : req_store_p0;
        cur_size  = acc_size(cur_opsel);
        cur_ofs   = align_ofs(cur_addr[1:0], cur_size);
        cur_idx   = cur_addr[AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        cur_misal = is_misaligned(cur_addr[1:0], cur_size);
`else
        cur_misal = 1'b0;
`endif
        case (cur_size)
            2'd0: begin
                cur_be   = 4'b0001 << cur_ofs;
                cur_lane = {4{cur_wdata[7:0]}};
            end
            2'd1: begin
                cur_be   = cur_ofs[1] ? 4'b1100 : 4'b0011;
                cur_lane = {2{cur_wdata[15:0]}};
            end
            default: begin
                cur_be   = 4'b1111;
                cur_lane = cur_wdata;
            end
        endcase
        go_resp = !i_rst &&
                  (((state == S_IDLE) && accept && DIRECT) ||
                   ((state == S_WAIT) && (cnt == CNT_W'(1))));
    end

    // Stage p0: request capture
    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_addr_p0  <= i_dmem_addr[AW+1:0];
            req_wdata_p0 <= i_dmem_wdata;
            req_opsel_p0 <= i_dmem_opsel;
            req_store_p0 <= i_dmem_wen;
        end
    end

    // Stage p1: array access on the edge entering RESP
    always_ff @(posedge i_clk) begin
        if (go_resp) begin
            if (cur_store && !cur_misal) begin
                for (int i = 0; i < 4; i++) begin
                    if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_lane[8*i +: 8];
                end
            end
            rd_word_p1 <= mem[cur_idx];
            ofs_p1     <= cur_ofs;
            opsel_p1   <= cur_opsel;
            store_p1   <= cur_store;
            misal_p1   <= cur_misal;
        end
    end

    // Control FSM and response stage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            o_dmem_valid <= 1'b0;
            o_dmem_err   <= 1'b0;
            o_dmem_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= DIRECT ? S_RESP : S_WAIT;
                        cnt   <= CNT_W'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) state <= S_RESP;
                    else                  cnt   <= cnt - CNT_W'(1);
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            o_dmem_valid <= (state == S_RESP);
            o_dmem_err   <= (state == S_RESP) && misal_p1;
            if (state == S_RESP) begin
                o_dmem_rdata <= (store_p1 || misal_p1) ? 32'h0
                                                       : extend_load(rd_word_p1, ofs_p1, opsel_p1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: LATENCY=1 and LATENCY=4 instances driven by one request bus.
module tb_dmem_resp;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [2:0]  opsel;
    logic        ready1, valid1, err1, ready4, valid4, err4;
    logic [31:0] rdata1, rdata4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst(rst1), .i_dmem_ren(ren), .i_dmem_wen(wen),
        .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_opsel(opsel),
        .o_dmem_ready(ready1), .o_dmem_valid(valid1), .o_dmem_rdata(rdata1), .o_dmem_err(err1)
    );

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .i_clk(clk), .i_rst(rst4), .i_dmem_ren(ren), .i_dmem_wen(wen),
        .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_opsel(opsel),
        .o_dmem_ready(ready4), .o_dmem_valid(valid4), .o_dmem_rdata(rdata4), .o_dmem_err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request presented to both instances; response pulse, timing and data checked on each
    task automatic xact(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                        input logic [31:0] exp1, input logic [31:0] exp4, input logic exp_err);
        int n1, n4, at1, at4;
        logic [31:0] rd1, rd4;
        logic e1, e4;
        n1 = 0; n4 = 0; at1 = 0; at4 = 0; rd1 = 'x; rd4 = 'x; e1 = 1'bx; e4 = 1'bx;
        @(negedge clk);
        ren = r; wen = w; addr = a; wdata = d; opsel = op;
        @(posedge clk);
        #1;
        ren = 1'b0; wen = 1'b0;
        chk({tag, ".busy1"}, 32'(ready1), 32'd0);
        chk({tag, ".busy4"}, 32'(ready4), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (valid1) begin n1++; at1 = k; rd1 = rdata1; e1 = err1; end
            if (valid4) begin n4++; at4 = k; rd4 = rdata4; e4 = err4; end
            if (k == 1) chk({tag, ".rdy1"}, 32'(ready1), 32'd1);
        end
        chk({tag, ".npulse1"}, 32'(n1), 32'd1);
        chk({tag, ".lat1"},    32'(at1), 32'd1);
        chk({tag, ".npulse4"}, 32'(n4), 32'd1);
        chk({tag, ".lat4"},    32'(at4), 32'd4);
        chk({tag, ".rdata1"},  rd1, exp1);
        chk({tag, ".rdata4"},  rd4, exp4);
        chk({tag, ".err1"},    32'(e1), 32'(exp_err));
        chk({tag, ".err4"},    32'(e4), 32'(exp_err));
    endtask

    initial begin
        logic [19:0] acc4, v4;
        int nacc1, nv1, nv4r;

        rst1 = 1'b1; rst4 = 1'b1;
        ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; opsel = 3'b010;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready1", 32'(ready1), 32'd0);
        chk("rst.ready4", 32'(ready4), 32'd0);
        chk("rst.valid1", 32'(valid1), 32'd0);
        chk("rst.valid4", 32'(valid4), 32'd0);
        chk("rst.rdata1", rdata1, 32'h0);
        chk("rst.rdata4", rdata4, 32'h0);
        chk("rst.err4",   32'(err4), 32'd0);
        @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;
        #1;
        chk("post_rst.ready1", 32'(ready1), 32'd1);
        chk("post_rst.ready4", 32'(ready4), 32'd1);

        xact("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 32'h0, 1'b0);
        xact("lw10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);

        xact("sw20",   1'b0, 1'b1, 32'h20, 32'h80F07F01, 3'b010, 32'h0, 32'h0, 1'b0);
        xact("lb23",   1'b1, 1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 32'hFFFFFF80, 1'b0);
        xact("lbu23",  1'b1, 1'b0, 32'h23, 32'h0, 3'b100, 32'h00000080, 32'h00000080, 1'b0);
        xact("lh20",   1'b1, 1'b0, 32'h20, 32'h0, 3'b001, 32'h00007F01, 32'h00007F01, 1'b0);
        xact("lh22",   1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF80F0, 32'hFFFF80F0, 1'b0);
        xact("lhu22",  1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 32'h000080F0, 32'h000080F0, 1'b0);

        xact("sw40",   1'b0, 1'b1, 32'h40, 32'h11223344, 3'b010, 32'h0, 32'h0, 1'b0);
        xact("sb41",   1'b0, 1'b1, 32'h41, 32'h123456AA, 3'b000, 32'h0, 32'h0, 1'b0);
        xact("sh42",   1'b0, 1'b1, 32'h42, 32'h9999BEEF, 3'b001, 32'h0, 32'h0, 1'b0);
        xact("lw40",   1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'hBEEFAA44, 32'hBEEFAA44, 1'b0);
        xact("lill40", 1'b1, 1'b0, 32'h40, 32'h0, 3'b011, 32'hBEEFAA44, 32'hBEEFAA44, 1'b0);

        xact("rwboth60", 1'b1, 1'b1, 32'h60, 32'hCAFEF00D, 3'b010, 32'h0, 32'h0, 1'b0);
        xact("lw60",     1'b1, 1'b0, 32'h60, 32'h0, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);

        xact("sw1000", 1'b0, 1'b1, 32'h1000, 32'h5A5A5A5A, 3'b010, 32'h0, 32'h0, 1'b0);
        xact("lw0",    1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0);

        // Request held high: LATENCY=4 accepts at edges 0,5,10 and responds at 4,9,14
        acc4 = '0; v4 = '0; nacc1 = 0; nv1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ren = (i <= 10); wen = 1'b0; addr = 32'h10; opsel = 3'b010;
            acc4[i] = ready4 && ren;
            if (ready1 && ren) nacc1++;
            @(posedge clk);
            #1;
            v4[i] = valid4;
            if (valid1) nv1++;
        end
        ren = 1'b0;
        chk("b2b.acc4",   32'(acc4), 32'h00421);
        chk("b2b.valid4", 32'(v4),   32'h04210);
        chk("b2b.acc1",   32'(nacc1), 32'd6);
        chk("b2b.valid1", 32'(nv1),   32'd6);

        // Store to word 0 aborted by reset while the LATENCY=4 instance waits
        @(negedge clk);
        wen = 1'b1; addr = 32'h0; wdata = 32'h0; opsel = 3'b010;
        @(posedge clk);
        #1;
        wen = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.ready_in_rst", 32'(ready4), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        nv4r = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (valid4) nv4r++;
        end
        chk("abort.no_valid", 32'(nv4r), 32'd0);
        chk("abort.rdata4",   rdata4, 32'h0);
        chk("abort.ready4",   32'(ready4), 32'd1);
        xact("lw0_after_abort", 1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0, 32'h5A5A5A5A, 1'b0);

        // Misaligned accesses against word 0x80F07F01 at 0x20
        xact("lw22_mis", 1'b1, 1'b0, 32'h22, 32'h0, 3'b010,
             TRAP ? 32'h0 : 32'h80F07F01, TRAP ? 32'h0 : 32'h80F07F01, TRAP);
        xact("sw21_mis", 1'b0, 1'b1, 32'h21, 32'h12345678, 3'b010, 32'h0, 32'h0, TRAP);
        xact("lw20_chk", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010,
             TRAP ? 32'h80F07F01 : 32'h12345678, TRAP ? 32'h80F07F01 : 32'h12345678, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Data-memory responder that sits opposite the execute stage's data-memory request port. It accepts load/store requests (address, write data, access size via funct3) and owns a word-organised, byte-addressable SRAM array. It completes each access after a fixed latency and returns extracted, sign- or zero-extended load data with a one-cycle valid pulse. A single-outstanding handshake lets the pipeline stall on `o_dmem_ready`.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, ≥2
LATENCY, 1, cycles from request accept to response valid; integer ≥1
AW, $clog2(DEPTH_WORDS), word-index width (derived, not overridden)

Ports:
i_clk  input  1  global clock
i_rst  input  1  synchronous, active-high reset
i_dmem_ren  input  1  load request
i_dmem_wen  input  1  store request
i_dmem_addr  input  32  byte address
i_dmem_wdata  input  32  store data, right-justified
i_dmem_opsel  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
o_dmem_ready  output  1  responder idle, request accepted this cycle
o_dmem_valid  output  1  one-cycle response pulse (load data or store ack)
o_dmem_rdata  output  32  extended load data
o_dmem_err  output  1  response flagged misaligned (see Optional Feature)

Behaviour:
- Reset/clock: all state is synchronous to `i_clk`. Synchronous active-high `i_rst` is already decided.
- Reset values:
  - FSM = IDLE, `o_dmem_valid` = 0, `o_dmem_rdata` = 0, `o_dmem_err` = 0.
  - `o_dmem_ready` = 0 while `i_rst` is high, 1 in the first cycle after.
  - Array contents are not reset.
- Accept: a request is taken when `o_dmem_ready` & (`i_dmem_ren` | `i_dmem_wen`) at a rising edge. The request is latched: address, wdata, opsel, type.
- Simultaneous `i_dmem_ren` and `i_dmem_wen`: treated as a store. Ack `o_dmem_rdata` = 0.
- FSM:
  - IDLE → WAIT on accept when LATENCY > 1; IDLE → RESP when LATENCY = 1.
  - WAIT: down-counter loaded with LATENCY−1 at accept; decrements each cycle; → RESP when it reaches 1.
  - RESP → IDLE unconditionally.
- `o_dmem_ready` = (state == IDLE) & ~`i_rst`. One outstanding request; throughput is one access per LATENCY+1 cycles.
- Response timing: for a request accepted at edge T, `o_dmem_valid` = 1 for exactly the cycle following edge T+LATENCY.
- Store commit and load sampling both happen on the edge entering RESP.
- `o_dmem_rdata` holds its value until the next response. A store response sets it to 0.
- Indexing: word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS.
- Store byte lanes:
  - b: lane addr[1:0], data wdata[7:0].
  - h: lanes {addr[1],0} and {addr[1],1}, data wdata[15:0].
  - w: all four lanes.
  - Untouched lanes keep their old value.
- Load extraction:
  - b/bu: byte at addr[1:0].
  - h/hu: halfword at addr[1].
  - w: full word.
  - b and h sign-extend from bit 7 and bit 15; bu and hu zero-extend.
- Illegal opsel (011, 110, 111): treated as word access.
- Inputs ignored while not ready: no queuing. The requester must hold the request until ready is seen high.
- Reset mid-operation (WAIT or RESP): the access is aborted, a pending store is not committed, and no valid pulse is issued.
- Read-after-write: a load accepted after a store's RESP cycle sees the stored data.

Optional Feature:
Macro: DMEM_MISALIGN_TRAP_EN
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is accepted and follows normal FSM timing.
  - The array is not read or written.
  - Response: `o_dmem_valid` = 1, `o_dmem_err` = 1, `o_dmem_rdata` = 0.
  - `o_dmem_err` = 0 on all aligned responses and is cleared with `o_dmem_valid`.
- Undefined:
  - Low address bits below access size are ignored: halfword forces addr[0] = 0, word forces addr[1:0] = 0.
  - `o_dmem_err` is tied to 0.

Test Plan:
1. LATENCY=1: store w addr 0x10 data 0xDEADBEEF, then load w 0x10 → ready low 1 cycle each. Load valid 2 cycles after accept edge... precisely valid in cycle after edge T+1. rdata = 0xDEADBEEF.
2. Byte/half extraction: word 0x80F07F01 at 0x20. lb 0x23 → 0xFFFFFF80; lbu 0x23 → 0x00000080; lh 0x20 → 0x00007F01; lh 0x22 → 0xFFFF80F0; lhu 0x22 → 0x000080F0.
3. Partial store: word 0x11223344 at 0x40, sb 0xAA at 0x41, sh 0xBEEF at 0x42 → lw 0x40 = 0xBEEFAA44.
4. LATENCY=4, back-to-back requests held high → accepts spaced 5 cycles apart. Exactly one valid pulse per request, each 4 cycles after its accept.
5. Wrap and reset: DEPTH_WORDS=1024, sw 0x1000 data 0x5A5A5A5A → lw 0x0 = 0x5A5A5A5A. Then a store of 0x0 accepted at LATENCY=4 with `i_rst` pulsed in WAIT → no valid, lw 0x0 still returns 0x5A5A5A5A.
6. DMEM_MISALIGN_TRAP_EN: lw 0x22 → valid=1, err=1, rdata=0; sw 0x21 leaves the word unchanged. Without the macro: lw 0x22 returns the word at 0x20, err=0.
